// File: rtl/dnn_cycle_feeder_if.sv
// Sample-store / DNN feed bus: full vectors in, selected slices plus block timing out.
// master = the feeder (dnn_cycle_feeder); slave = the datapath/evaluation side.
interface dnn_cycle_feeder_if #(
   parameter int CPC       = 18,
   parameter int A_W       = 512,
   parameter int Y_W       = 1,
   parameter int NUM_CASES = 50000
);
   localparam int NS = CPC - 2;
   localparam int CW = $clog2(CPC);
   localparam int SW = $clog2(NS);
   localparam int TW = $clog2(NUM_CASES);

   logic [A_W*NS-1:0] a_full;
   logic [Y_W*NS-1:0] y_full;
   logic [A_W-1:0]    a_in;
   logic [Y_W-1:0]    y_in;
   logic [CW-1:0]     count;
   logic [SW-1:0]     sel;
   logic              feed_valid;
   logic              cycle_clk;
   logic [TW-1:0]     case_idx;
   logic              epoch_done;

   modport master (
      input  a_full, y_full,
      output a_in, y_in, count, sel, feed_valid, cycle_clk, case_idx, epoch_done
   );

   modport slave (
      output a_full, y_full,
      input  a_in, y_in, count, sel, feed_valid, cycle_clk, case_idx, epoch_done
   );
endinterface

// File: rtl/dnn_cycle_feeder.sv
// Per-sample sequencer: block cycle counter, slice mux (zero latency) and case index with epoch wrap.
// No backpressure; free-running. `define FEED_ZERO_IDLE_EN zeroes a_in/y_in at count 0 and 1.
module dnn_cycle_feeder #(
   parameter int CPC       = 18,
   parameter int A_W       = 512,
   parameter int Y_W       = 1,
   parameter int NUM_CASES = 50000,
   parameter int CASE_INIT = 10000
) (
   input  logic               clk,
   input  logic               reset,
   dnn_cycle_feeder_if.master bus
);
   localparam int NS = CPC - 2;
   localparam int CW = $clog2(CPC);
   localparam int SW = $clog2(NS);
   localparam int TW = $clog2(NUM_CASES);

   localparam logic [CW-1:0] CNT_LAST  = CW'(CPC - 1);
   localparam logic [TW-1:0] CASE_LAST = TW'(NUM_CASES - 1);
   localparam logic [TW-1:0] CASE_RST  = TW'(CASE_INIT);

   logic [CW-1:0]  count_q, count_d;
   logic [TW-1:0]  case_idx_q, case_idx_d;
   logic           at_last;
   logic           feed_valid;
   logic [CW-1:0]  count_m2;
   logic [SW-1:0]  sel;
   int unsigned    sel_idx;
   logic [A_W-1:0] a_sel;
   logic [Y_W-1:0] y_sel;

   always_comb begin
      at_last    = (count_q == CNT_LAST);
      count_d    = at_last ? '0 : count_q + CW'(1);
      case_idx_d = case_idx_q;
      if (at_last) begin
         case_idx_d = (case_idx_q == CASE_LAST) ? '0 : case_idx_q + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q    <= '0;
         case_idx_q <= CASE_RST;
      end else begin
         count_q    <= count_d;
         case_idx_q <= case_idx_d;
      end
   end

   // NS is a power of two, so truncating (count-2) wraps counts 0/1 onto the last two slices.
   always_comb begin
      feed_valid = (count_q >= CW'(2));
      count_m2   = count_q - CW'(2);
      sel        = count_m2[SW-1:0];
      sel_idx    = 32'(sel);
      a_sel      = bus.a_full[sel_idx*A_W +: A_W];
      y_sel      = bus.y_full[sel_idx*Y_W +: Y_W];
`ifdef FEED_ZERO_IDLE_EN
      if (!feed_valid) begin
         a_sel = '0;
         y_sel = '0;
      end
`endif
   end

   assign bus.a_in       = a_sel;
   assign bus.y_in       = y_sel;
   assign bus.count      = count_q;
   assign bus.sel        = sel;
   assign bus.feed_valid = feed_valid;
   assign bus.cycle_clk  = at_last;
   assign bus.case_idx   = case_idx_q;
   assign bus.epoch_done = at_last && (case_idx_q == CASE_LAST);
endmodule

// File: tb/tb_dnn_cycle_feeder.sv
// Three feeder configurations driven in lockstep and compared against a cycles-since-reset model.
module tb_dnn_cycle_feeder;
   logic clk = 1'b0;
   logic reset;
   int   t;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [511:0] sl [3][16];
   logic [7:0]   ys [3][16];

   always #5 clk = ~clk;

   dnn_cycle_feeder_if #(.CPC(18), .A_W(512), .Y_W(1), .NUM_CASES(50000)) ifa ();
   dnn_cycle_feeder_if #(.CPC(18), .A_W(16),  .Y_W(1), .NUM_CASES(4))     ifb ();
   dnn_cycle_feeder_if #(.CPC(4),  .A_W(8),   .Y_W(2), .NUM_CASES(5))     ifc ();

   dnn_cycle_feeder #(.CPC(18), .A_W(512), .Y_W(1), .NUM_CASES(50000), .CASE_INIT(10000))
      dut_a (.clk(clk), .reset(reset), .bus(ifa));
   dnn_cycle_feeder #(.CPC(18), .A_W(16), .Y_W(1), .NUM_CASES(4), .CASE_INIT(2))
      dut_b (.clk(clk), .reset(reset), .bus(ifb));
   dnn_cycle_feeder #(.CPC(4), .A_W(8), .Y_W(2), .NUM_CASES(5), .CASE_INIT(3))
      dut_c (.clk(clk), .reset(reset), .bus(ifc));

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d got=%h want=%h", tag, t, obs, exp);
      end
   endtask

   // Expected values come from elapsed cycles since the last reset edge.
   task automatic check_dut(input string nm, input int d, input int cpc, input int ncases,
                            input int init, input int aw, input int yw,
                            input logic [31:0] o_cnt, input logic [31:0] o_sel,
                            input logic o_fv, input logic o_cc, input logic [31:0] o_case,
                            input logic o_ed, input logic [511:0] o_a, input logic [7:0] o_y);
      int ns, c, k, e_sel;
      logic [511:0] amask, e_a;
      logic [7:0]   ymask, e_y;
      ns    = cpc - 2;
      c     = t % cpc;
      k     = (init + t / cpc) % ncases;
      e_sel = (c + ns - 2) % ns;
      amask = (aw >= 512) ? '1 : ((512'(1) << aw) - 512'(1));
      ymask = (yw >= 8) ? '1 : ((8'(1) << yw) - 8'(1));
      e_a   = sl[d][e_sel] & amask;
      e_y   = ys[d][e_sel] & ymask;
`ifdef FEED_ZERO_IDLE_EN
      if (c < 2) begin
         e_a = '0;
         e_y = '0;
      end
`endif
      check({nm, ".count"},      512'(o_cnt),  512'(c));
      check({nm, ".sel"},        512'(o_sel),  512'(e_sel));
      check({nm, ".feed_valid"}, 512'(o_fv),   512'(c >= 2));
      check({nm, ".cycle_clk"},  512'(o_cc),   512'(c == cpc - 1));
      check({nm, ".case_idx"},   512'(o_case), 512'(k));
      check({nm, ".epoch_done"}, 512'(o_ed),   512'((c == cpc - 1) && (k == ncases - 1)));
      check({nm, ".a_in"},       o_a,          e_a);
      check({nm, ".y_in"},       512'(o_y),    512'(e_y));
   endtask

   task automatic check_all();
      check_dut("a", 0, 18, 50000, 10000, 512, 1, 32'(ifa.count), 32'(ifa.sel), ifa.feed_valid,
                ifa.cycle_clk, 32'(ifa.case_idx), ifa.epoch_done, 512'(ifa.a_in), 8'(ifa.y_in));
      check_dut("b", 1, 18, 4, 2, 16, 1, 32'(ifb.count), 32'(ifb.sel), ifb.feed_valid,
                ifb.cycle_clk, 32'(ifb.case_idx), ifb.epoch_done, 512'(ifb.a_in), 8'(ifb.y_in));
      check_dut("c", 2, 4, 5, 3, 8, 2, 32'(ifc.count), 32'(ifc.sel), ifc.feed_valid,
                ifc.cycle_clk, 32'(ifc.case_idx), ifc.epoch_done, 512'(ifc.a_in), 8'(ifc.y_in));
   endtask

   task automatic fill_directed();
      for (int d = 0; d < 3; d++) begin
         for (int k = 0; k < 16; k++) begin
            sl[d][k] = {64{8'(k + 1)}};
            ys[d][k] = 8'(k % 3 == 0);
         end
      end
   endtask

   task automatic fill_random();
      for (int d = 0; d < 3; d++) begin
         for (int k = 0; k < 16; k++) begin
            for (int w = 0; w < 16; w++) sl[d][k][w*32 +: 32] = $urandom;
            ys[d][k] = 8'($urandom);
         end
      end
   endtask

   task automatic drive();
      for (int k = 0; k < 16; k++) begin
         ifa.a_full[k*512 +: 512] = sl[0][k];
         ifa.y_full[k]            = ys[0][k][0];
         ifb.a_full[k*16 +: 16]   = sl[1][k][15:0];
         ifb.y_full[k]            = ys[1][k][0];
      end
      for (int k = 0; k < 2; k++) begin
         ifc.a_full[k*8 +: 8] = sl[2][k][7:0];
         ifc.y_full[k*2 +: 2] = ys[2][k][1:0];
      end
   endtask

   task automatic step(input logic rst_val, input bit rnd);
      reset = rst_val;
      @(posedge clk);
      #1;
      if (!rst_val) t = 0;
      else          t++;
      if (rnd) fill_random();
      drive();
      #1;
      check_all();
   endtask

   initial begin
      t     = 0;
      reset = 1'b0;
      fill_directed();
      drive();
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      for (int i = 0; i < 60; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 120; i++) step(1'b1, 1'b1);
      for (int i = 0; i < 18 && (t % 18) != 9; i++) step(1'b1, 1'b1);
      check("abort_at_count9", 512'(ifa.count), 512'(9));
      step(1'b0, 1'b1);
      for (int i = 0; i < 200; i++) step(1'b1, 1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
